// File: rtl/cache_refill_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cache_refill_ctrl                                                        |
// | Critical-word-first cache line refill sequencer with wrap-around order.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module cache_refill_ctrl #(
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss_valid,
  input  logic [ADDR_W-1:0] miss_addr,
  output logic              miss_ready,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              fill_we,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [31:0]       fill_data,
  output logic              crit_valid,
  output logic [31:0]       crit_data,
  output logic              fill_done,
  output logic              busy,
  output logic [31:0]       refill_count
);

  localparam int               OFF_W       = $clog2(WORDS_PER_LINE);
  localparam logic [OFF_W-1:0] C_LAST_WORD = OFF_W'(WORDS_PER_LINE - 1);
  localparam logic [ADDR_W-1:0] C_LINE_MASK = ADDR_W'(WORDS_PER_LINE * 4 - 1);
  localparam logic [ADDR_W-1:0] C_WORD_MASK = ADDR_W'(3);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             r_state;
  logic [ADDR_W-1:0]  r_base;
  logic [OFF_W-1:0]   r_start;
  logic [OFF_W-1:0]   r_k;
  logic [OFF_W-1:0]   w_next_off;
  logic [ADDR_W-1:0]  w_next_addr;

  // Offset arithmetic is OFF_W bits wide, so it wraps inside the line and never carries into the base.
  always_comb begin
    w_next_off                = r_start + r_k + OFF_W'(1);
    w_next_addr               = r_base;
    w_next_addr[OFF_W+1:2]    = w_next_off;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_base       <= '0;
      r_start      <= '0;
      r_k          <= '0;
      miss_ready   <= 1'b1;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
      fill_we      <= 1'b0;
      fill_addr    <= '0;
      fill_data    <= '0;
      crit_valid   <= 1'b0;
      crit_data    <= '0;
      fill_done    <= 1'b0;
      busy         <= 1'b0;
      refill_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (miss_valid) begin
            r_base     <= miss_addr & ~C_LINE_MASK;
            r_start    <= miss_addr[OFF_W+1:2];
            r_k        <= '0;
            mem_addr   <= miss_addr & ~C_WORD_MASK;
            mem_req    <= 1'b1;
            miss_ready <= 1'b0;
            busy       <= 1'b1;
            r_state    <= REQ;
          end
        end
        REQ: begin
          if (mem_ack) begin
            mem_req    <= 1'b0;
            fill_we    <= 1'b1;
            fill_addr  <= mem_addr;
            fill_data  <= mem_rdata;
            if (r_k == '0) begin
              crit_valid <= 1'b1;
              crit_data  <= mem_rdata;
            end
            r_state    <= WRITE;
          end
        end
        WRITE: begin
          fill_we    <= 1'b0;
          crit_valid <= 1'b0;
          if (r_k == C_LAST_WORD) begin
            fill_done <= 1'b1;
            r_state   <= DONE;
          end else begin
            r_k      <= r_k + OFF_W'(1);
            mem_addr <= w_next_addr;
            mem_req  <= 1'b1;
            r_state  <= REQ;
          end
        end
        DONE: begin
          fill_done  <= 1'b0;
          if (refill_count != 32'hFFFF_FFFF) begin
            refill_count <= refill_count + 32'd1;
          end
          miss_ready <= 1'b1;
          busy       <= 1'b0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/cache_refill_ctrl.md
CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

Interface
REQ-001 Parameter WORDS_PER_LINE, default 4: 32-bit words per cache line; power of two, 2..16.
REQ-002 Parameter ADDR_W, default 32: byte-address width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 miss_valid  in  1  cache reports a read miss; held high until accepted.
REQ-006 miss_addr  in  ADDR_W  byte address of the missing word; stable while miss_valid is high.
REQ-007 miss_ready  out  1  controller can accept a miss.
REQ-008 mem_req  out  1  word read request to backing memory.
REQ-009 mem_addr  out  ADDR_W  word-aligned byte address of the request.
REQ-010 mem_ack  in  1  one-cycle pulse; mem_rdata valid in the same cycle.
REQ-011 mem_rdata  in  32  returned memory word.
REQ-012 fill_we  out  1  one-cycle write strobe into the cache data array.
REQ-013 fill_addr  out  ADDR_W  word-aligned byte address being written.
REQ-014 fill_data  out  32  word being written.
REQ-015 crit_valid  out  1  one-cycle pulse forwarding the originally missed word.
REQ-016 crit_data  out  32  missed word; valid only while crit_valid is high.
REQ-017 fill_done  out  1  one-cycle pulse after the last word of a line is written.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 refill_count  out  32  completed refills; saturates at 0xFFFF_FFFF.

Function
REQ-020 States are IDLE, REQ, WRITE and DONE; all outputs are registered.
REQ-021 IDLE: miss_ready=1; miss_valid=1 latches miss_addr, zeroes the word counter and moves to REQ.
REQ-022 Offset bits are miss_addr[log2(WORDS_PER_LINE)+1:2], and line base is miss_addr with the offset and [1:0] bits cleared.
REQ-023 Fill order is critical-word-first with wrap: word k (k=0..WORDS_PER_LINE-1) uses offset (start_offset+k) mod WORDS_PER_LINE.
REQ-024 REQ: mem_req=1 and mem_addr=line_base+4*offset(k); both hold until mem_ack.
REQ-025 REQ with mem_ack=1 registers mem_rdata and moves to WRITE; mem_req is low in the following cycle.
REQ-026 WRITE: fill_we=1 with fill_addr=mem_addr(k) and fill_data=captured word, for exactly one cycle.
REQ-027 WRITE with k=0 also drives crit_valid=1 and crit_data=fill_data in the same cycle.
REQ-028 WRITE with k<WORDS_PER_LINE-1 increments k and returns to REQ.
REQ-029 WRITE with k=WORDS_PER_LINE-1 moves to DONE.
REQ-030 DONE: fill_done=1 for one cycle, refill_count increments unless saturated, then return to IDLE.
REQ-031 mem_ack outside REQ is ignored; it changes no state, data or counters.
REQ-032 A new miss_valid while busy is not accepted (miss_ready=0); the cache must hold it, and it is accepted in the next IDLE cycle.
REQ-033 With zero-wait memory (mem_ack in the first REQ cycle), a refill accepted at edge T gives the last fill_we at T+2*WORDS_PER_LINE, fill_done at T+2*WORDS_PER_LINE+1 and miss_ready at T+2*WORDS_PER_LINE+2.
REQ-034 Wait states extend REQ only; the word order and the one-cycle WRITE/DONE pulses are unchanged.
REQ-035 Address arithmetic wraps within the line only; line_base never carries into higher bits, including for miss_addr=0xFFFF_FFFC.

Reset
REQ-036 rst_n=0 immediately forces IDLE; miss_ready=1; all other outputs 0; word counter 0; refill_count 0.
REQ-037 Reset mid-refill abandons the line without fill_done or a count increment; a mem_ack arriving after reset release is ignored per REQ-031.

Verification
REQ-038 WORDS_PER_LINE=4, miss_addr=0x0000_1008, zero-wait acks returning 0xA0..0xA3 -> mem_addr sequence 0x1008,0x100C,0x1000,0x1004; crit_data=0xA0 at the first fill_we; fill_done at T+9; refill_count=1.
REQ-039 miss_addr=0x0000_200C with 3 wait cycles per word -> order 0x200C,0x2000,0x2004,0x2008; mem_req and mem_addr held through the waits; exactly 4 fill_we pulses.
REQ-040 Second miss_valid asserted during a refill -> miss_ready=0 until IDLE; second refill starts the cycle after IDLE is entered; refill_count=2.
REQ-041 rst_n pulled low after 2 words, then a stray mem_ack -> outputs cleared asynchronously; no fill_done; refill_count=0; stray ack produces no fill_we.
REQ-042 Spurious mem_ack in IDLE, and refill_count preloaded (via force) to 0xFFFF_FFFF followed by one refill -> no state change; count stays 0xFFFF_FFFF.
REQ-043 miss_addr=0xFFFF_FFFC, WORDS_PER_LINE=4 -> addresses 0xFFFF_FFFC,0xFFFF_FFF0,0xFFFF_FFF4,0xFFFF_FFF8.
